// File: rtl/uniq_lru_pkg.sv
// Shared types, defaults and helpers for the uniq_lru recent-unique-value tracker.
package uniq_lru_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 4;

  // Slot index for the default geometry
  typedef logic [$clog2(DefaultDepth)-1:0] slot_idx_t;

  // Bits needed to hold a count from 0 to depth inclusive
  function automatic int unsigned clog2_p1(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uniq_lru_match.sv
// DEPTH-way equality compare of a sample against the occupied slots, lowest index wins.
module uniq_lru_match
  import uniq_lru_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic [WIDTH-1:0]         data_i,
  input  logic [DEPTH*WIDTH-1:0]   slots_i,
  input  logic [DEPTH-1:0]         valid_i,
  output logic                     match_o,
  output logic [$clog2(DEPTH)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  // Scan from the top so the lowest matching index is the one left standing
  always_comb begin
    match_o = 1'b0;
    idx_o   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_i[k] && (slots_i[k*WIDTH +: WIDTH] == data_i)) begin
        match_o = 1'b1;
        idx_o   = IdxW'(k);
      end
    end
  end

endmodule

// File: rtl/uniq_lru.sv
// Recent-unique-value tracker: DEPTH distinct values in move-to-front order, slot 0 newest.
// Optional hit/miss statistics counters are built when UNIQ_LRU_STATS_EN is defined.
module uniq_lru
  import uniq_lru_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned CNT_W = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          data_valid_in,
  input  logic                          clear_in,
  output logic [DEPTH*WIDTH-1:0]        data_out,
  output logic [DEPTH-1:0]              data_out_valid,
  output logic [clog2_p1(DEPTH)-1:0]    count_out,
`ifdef UNIQ_LRU_STATS_EN
  output logic [CNT_W-1:0]              hit_cnt_out,
  output logic [CNT_W-1:0]              miss_cnt_out,
`endif
  output logic                          hit_out,
  output logic [$clog2(DEPTH)-1:0]      hit_idx_out,
  output logic                          evict_valid_out,
  output logic [WIDTH-1:0]              evict_out
);

  localparam int unsigned CntW = clog2_p1(DEPTH);
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  if (DEPTH < 2 || CNT_W < 1) begin : g_bad_params
    $error("uniq_lru: DEPTH must be >= 2 and CNT_W >= 1");
  end

  logic [DEPTH*WIDTH-1:0] slot_q, slot_d;
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   hit_q, hit_d;
  logic [IdxW-1:0]        hit_idx_q, hit_idx_d;
  logic                   evict_v_q, evict_v_d;
  logic [WIDTH-1:0]       evict_q, evict_d;

  logic                   match;
  logic [IdxW-1:0]        match_idx;
  logic                   accept;

  assign accept = data_valid_in && !clear_in;

  uniq_lru_match #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_match (
    .data_i  (data_in),
    .slots_i (slot_q),
    .valid_i (valid_q),
    .match_o (match),
    .idx_o   (match_idx)
  );

  // Next-state for slots, occupancy and the one-cycle hit/evict pulses
  always_comb begin
    slot_d    = slot_q;
    valid_d   = valid_q;
    count_d   = count_q;
    hit_d     = 1'b0;
    hit_idx_d = '0;
    evict_v_d = 1'b0;
    evict_d   = '0;
    if (clear_in) begin
      slot_d  = '0;
      valid_d = '0;
      count_d = '0;
    end else if (data_valid_in) begin
      if (match) begin
        // Close the gap at the hit slot; everything above it stays put
        for (int k = 1; k < DEPTH; k++) begin
          if (k <= int'(match_idx)) begin
            slot_d[k*WIDTH +: WIDTH] = slot_q[(k-1)*WIDTH +: WIDTH];
          end
        end
        slot_d[WIDTH-1:0] = data_in;
        hit_d             = 1'b1;
        hit_idx_d         = match_idx;
      end else begin
        slot_d  = {slot_q[(DEPTH-1)*WIDTH-1:0], data_in};
        valid_d = {valid_q[DEPTH-2:0], 1'b1};
        if (count_q == FullCount) begin
          evict_v_d = 1'b1;
          evict_d   = slot_q[(DEPTH-1)*WIDTH +: WIDTH];
        end else begin
          count_d = count_q + CntW'(1);
        end
      end
    end
  end

  // Main state and output registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      slot_q    <= '0;
      valid_q   <= '0;
      count_q   <= '0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      evict_v_q <= 1'b0;
      evict_q   <= '0;
    end else begin
      slot_q    <= slot_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      evict_v_q <= evict_v_d;
      evict_q   <= evict_d;
    end
  end

  assign data_out        = slot_q;
  assign data_out_valid  = valid_q;
  assign count_out       = count_q;
  assign hit_out         = hit_q;
  assign hit_idx_out     = hit_idx_q;
  assign evict_valid_out = evict_v_q;
  assign evict_out       = evict_q;

`ifdef UNIQ_LRU_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Saturating hit/miss counters over accepted samples
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (clear_in) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (accept && match) begin
      if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end else if (accept) begin
      if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_out  = hit_cnt_q;
  assign miss_cnt_out = miss_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_uniq_lru.sv
// Self-checking bench for uniq_lru (WIDTH=8, DEPTH=4): directed scenarios plus random
// stimulus checked against a queue-based move-to-front reference model.
module tb_uniq_lru;
  import uniq_lru_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b1;
  logic [W-1:0]    data_in = '0;
  logic            data_valid_in = 1'b0;
  logic            clear_in = 1'b0;
  logic [D*W-1:0]  data_out;
  logic [D-1:0]    data_out_valid;
  logic [2:0]      count_out;
  logic            hit_out;
  slot_idx_t       hit_idx_out;
  logic            evict_valid_out;
  logic [W-1:0]    evict_out;
`ifdef UNIQ_LRU_STATS_EN
  logic [15:0]     hit_cnt_out, miss_cnt_out;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: newest at the front of the queue
  logic [W-1:0] mq[$];
  bit           m_hit;
  int           m_idx;
  bit           m_ev;
  logic [W-1:0] m_evv;
  int           m_hits, m_miss;

  uniq_lru #(
    .WIDTH (W),
    .DEPTH (D),
    .CNT_W (16)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .data_in         (data_in),
    .data_valid_in   (data_valid_in),
    .clear_in        (clear_in),
    .data_out        (data_out),
    .data_out_valid  (data_out_valid),
    .count_out       (count_out),
`ifdef UNIQ_LRU_STATS_EN
    .hit_cnt_out     (hit_cnt_out),
    .miss_cnt_out    (miss_cnt_out),
`endif
    .hit_out         (hit_out),
    .hit_idx_out     (hit_idx_out),
    .evict_valid_out (evict_valid_out),
    .evict_out       (evict_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_reset();
    mq.delete();
    m_hit = 0; m_idx = 0; m_ev = 0; m_evv = '0; m_hits = 0; m_miss = 0;
  endtask

  task automatic model_apply(input bit v, input bit c, input logic [W-1:0] d);
    int found;
    m_hit = 0; m_idx = 0; m_ev = 0; m_evv = '0;
    if (c) begin
      mq.delete();
      m_hits = 0;
      m_miss = 0;
    end else if (v) begin
      found = -1;
      foreach (mq[i]) if (found < 0 && mq[i] == d) found = i;
      if (found >= 0) begin
        m_hit = 1;
        m_idx = found;
        mq.delete(found);
        mq.push_front(d);
        if (m_hits < 65535) m_hits++;
      end else begin
        if (mq.size() == D) begin
          m_ev  = 1;
          m_evv = mq.pop_back();
        end
        mq.push_front(d);
        if (m_miss < 65535) m_miss++;
      end
    end
  endtask

  // One clock of stimulus; outputs are settled and sampled 1 ns after the edge
  task automatic step(input bit v, input bit c, input logic [W-1:0] d);
    @(negedge clk_in);
    data_valid_in = v;
    clear_in      = c;
    data_in       = d;
    model_apply(v, c, d);
    @(posedge clk_in);
    #1;
    data_valid_in = 1'b0;
    clear_in      = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    #1;
    checks++;
    if (data_out !== '0 || data_out_valid !== '0 || count_out !== '0 || hit_out !== 1'b0 ||
        hit_idx_out !== '0 || evict_valid_out !== 1'b0 || evict_out !== '0) begin
      errors++;
      $display("FAIL reset: data=%h valid=%b count=%0d hit=%b idx=%0d ev=%b evv=%h, required all 0",
               data_out, data_out_valid, count_out, hit_out, hit_idx_out, evict_valid_out,
               evict_out);
    end
  endtask

  task automatic test_fill();
    logic [W-1:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    foreach (vals[i]) begin
      step(1, 0, vals[i]);
      checks++;
      if (hit_out !== 1'b0) begin
        errors++;
        $display("FAIL fill_hit[%0d]: hit_out=%b required 0", i, hit_out);
      end
    end
    checks++;
    if (data_out !== 32'h0011_2233) begin
      errors++;
      $display("FAIL fill_data: got %h required 00112233", data_out);
    end
    checks++;
    if (data_out_valid !== 4'b0111 || count_out !== 3'd3) begin
      errors++;
      $display("FAIL fill_count: valid=%b count=%0d required 0111/3", data_out_valid, count_out);
    end
  endtask

  task automatic test_evict();
    step(1, 0, 8'h44);
    checks++;
    if (count_out !== 3'd4 || data_out_valid !== 4'b1111 || evict_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL full_no_evict: count=%0d valid=%b ev=%b required 4/1111/0",
               count_out, data_out_valid, evict_valid_out);
    end
    step(1, 0, 8'h55);
    checks++;
    if (evict_valid_out !== 1'b1 || evict_out !== 8'h11) begin
      errors++;
      $display("FAIL evict: ev=%b evv=%h required 1/11", evict_valid_out, evict_out);
    end
    checks++;
    if (data_out !== 32'h2233_4455 || count_out !== 3'd4) begin
      errors++;
      $display("FAIL evict_data: data=%h count=%0d required 22334455/4", data_out, count_out);
    end
  endtask

  task automatic test_hit();
    step(1, 0, 8'h33);
    checks++;
    if (hit_out !== 1'b1 || hit_idx_out !== 2'd2) begin
      errors++;
      $display("FAIL hit_mid: hit=%b idx=%0d required 1/2", hit_out, hit_idx_out);
    end
    checks++;
    if (data_out !== 32'h2244_5533 || count_out !== 3'd4 || evict_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL hit_mid_data: data=%h count=%0d ev=%b required 22445533/4/0",
               data_out, count_out, evict_valid_out);
    end
`ifdef UNIQ_LRU_STATS_EN
    checks++;
    if (hit_cnt_out !== 16'd1 || miss_cnt_out !== 16'd5) begin
      errors++;
      $display("FAIL stats: hits=%0d misses=%0d required 1/5", hit_cnt_out, miss_cnt_out);
    end
`endif
  endtask

  task automatic test_hold();
    step(1, 0, 8'h33);
    checks++;
    if (hit_out !== 1'b1 || hit_idx_out !== 2'd0 || data_out !== 32'h2244_5533) begin
      errors++;
      $display("FAIL hit_front: hit=%b idx=%0d data=%h required 1/0/22445533",
               hit_out, hit_idx_out, data_out);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 8'h33);
      checks++;
      if (hit_out !== 1'b0 || evict_valid_out !== 1'b0 || data_out !== 32'h2244_5533 ||
          count_out !== 3'd4) begin
        errors++;
        $display("FAIL idle[%0d]: hit=%b ev=%b data=%h count=%0d required 0/0/22445533/4",
                 i, hit_out, evict_valid_out, data_out, count_out);
      end
    end
  endtask

  task automatic test_clear();
    step(1, 1, 8'h99);
    checks++;
    if (count_out !== 3'd0 || data_out_valid !== 4'b0000 || data_out !== '0 ||
        hit_out !== 1'b0) begin
      errors++;
      $display("FAIL clear: count=%0d valid=%b data=%h hit=%b required 0/0000/0/0",
               count_out, data_out_valid, data_out, hit_out);
    end
    step(1, 0, 8'h99);
    checks++;
    if (hit_out !== 1'b0 || count_out !== 3'd1 || data_out !== 32'h0000_0099) begin
      errors++;
      $display("FAIL after_clear: hit=%b count=%0d data=%h required 0/1/00000099",
               hit_out, count_out, data_out);
    end
    // Empty slots hold zero but must never match a zero sample
    step(1, 0, 8'h00);
    checks++;
    if (hit_out !== 1'b0 || count_out !== 3'd2 || data_out !== 32'h0000_9900) begin
      errors++;
      $display("FAIL zero_no_hit: hit=%b count=%0d data=%h required 0/2/00009900",
               hit_out, count_out, data_out);
    end
  endtask

  task automatic test_random();
    logic [D*W-1:0] exp_data;
    logic [D-1:0]   exp_valid;
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
           W'($urandom_range(0, 7)));
      exp_data  = '0;
      exp_valid = '0;
      foreach (mq[i]) begin
        exp_data[i*W +: W] = mq[i];
        exp_valid[i]       = 1'b1;
      end
      checks++;
      if (data_out !== exp_data || data_out_valid !== exp_valid || count_out !== 3'(mq.size())) begin
        errors++;
        $display("FAIL rand_state[%0d]: data=%h valid=%b count=%0d required %h/%b/%0d",
                 n, data_out, data_out_valid, count_out, exp_data, exp_valid, mq.size());
      end
      checks++;
      if (hit_out !== m_hit || hit_idx_out !== slot_idx_t'(m_idx) ||
          evict_valid_out !== m_ev || evict_out !== m_evv) begin
        errors++;
        $display("FAIL rand_pulse[%0d]: hit=%b idx=%0d ev=%b evv=%h required %b/%0d/%b/%h",
                 n, hit_out, hit_idx_out, evict_valid_out, evict_out, m_hit, m_idx, m_ev, m_evv);
      end
`ifdef UNIQ_LRU_STATS_EN
      checks++;
      if (hit_cnt_out !== 16'(m_hits) || miss_cnt_out !== 16'(m_miss)) begin
        errors++;
        $display("FAIL rand_stats[%0d]: hits=%0d misses=%0d required %0d/%0d",
                 n, hit_cnt_out, miss_cnt_out, m_hits, m_miss);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) step(1, 0, W'(8'h40 + i));
    #2;
    rst_in = 1'b1;
    #1;
    checks++;
    if (data_out !== '0 || data_out_valid !== '0 || count_out !== '0 ||
        evict_valid_out !== 1'b0 || evict_out !== '0 || hit_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: data=%h valid=%b count=%0d ev=%b required all 0",
               data_out, data_out_valid, count_out, evict_valid_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    step(1, 0, 8'h7e);
    checks++;
    if (count_out !== 3'd1 || data_out !== 32'h0000_007e || evict_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: count=%0d data=%h ev=%b required 1/0000007e/0",
               count_out, data_out, evict_valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_evict();
    test_hit();
    test_hold();
    test_clear();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
